clk_gate_ctrl: RTL and testbench
================================

# clk_gate_ctrl

Clock-gating controller that produces the enable for a latch-based integrated clock gate cell. It turns the gated clock on when a consumer requests it, holds the consumer's acknowledge low until a wake-up settling window has elapsed, and turns the clock off after a programmable run of idle cycles. It sits in the always-on reference clock domain, alongside the system controller, in front of each gated block such as the ALU.

## Interface

Parameters:
- `WAKE_CYCLES`, default 2: cycles between `CLK_EN` rising and `ACK` rising; must be ≥1.
- `IDLE_TIMEOUT`, default 4: consecutive idle cycles before `CLK_EN` falls; must be ≥1.
- `CNT_W`, default 4: width of the shared down-counter; must hold max(`WAKE_CYCLES`, `IDLE_TIMEOUT`)−1.

Ports:
- `CLK`  in  1  always-on clock; the ungated source of the gate cell.
- `RST`  in  1  asynchronous, active-low reset.
- `REQ`  in  1  consumer requests a running clock; level-sensitive.
- `BUSY`  in  1  gated block still active; keeps the clock on.
- `FORCE_ON`  in  1  test/debug override; keeps the clock on.
- `CLK_EN`  out  1  enable to the clock gate cell; driven directly by a flop.
- `ACK`  out  1  gated clock is running and stable; driven directly by a flop.
- `STATE`  out  2  current FSM state, for debug and observation.

## Operation

- Define `wake = REQ | FORCE_ON` and `idle = ~REQ & ~BUSY & ~FORCE_ON`.
- The FSM is Moore with registered outputs. `CLK_EN` and `ACK` are computed from the next state and registered, so the gate enable never glitches.
- **OFF** (`CLK_EN`=0, `ACK`=0):
  - If `wake`, go to WAKE and load the counter with `WAKE_CYCLES`−1.
  - `BUSY` alone does not wake the clock.
- **WAKE** (`CLK_EN`=1, `ACK`=0):
  - If the counter is 0, go to ON; otherwise decrement.
  - Wake always completes. Dropping `REQ` mid-wake does not abort it, which avoids toggling the enable.
- **ON** (`CLK_EN`=1, `ACK`=1):
  - If `idle`, go to IDLE_WAIT and load the counter with `IDLE_TIMEOUT`−1.
- **IDLE_WAIT** (`CLK_EN`=1, `ACK`=0):
  - If not `idle`, return to ON; no wake window is needed because the clock never stopped.
  - Else if the counter is 0, go to OFF.
  - Else decrement.
- State encoding: OFF=2'b00, WAKE=2'b01, ON=2'b10, IDLE_WAIT=2'b11.
- Reset values: state OFF, counter 0, `CLK_EN`=0, `ACK`=0, `STATE`=2'b00.
- Reset asserted mid-operation clears everything immediately (asynchronously), including mid-WAKE and mid-IDLE_WAIT.
- Simultaneous events: in IDLE_WAIT, a non-idle input on the same edge the counter reaches 0 wins, and the FSM returns to ON.

## Timing

Edge numbers are rising `CLK` edges at which inputs are sampled.
- `REQ` high at edge e in OFF:
  - `CLK_EN`=1 after edge e.
  - `ACK`=1 after edge e+`WAKE_CYCLES`.
- `idle` at edge k in ON:
  - `ACK`=0 after edge k.
  - `CLK_EN`=0 after edge k+`IDLE_TIMEOUT`, provided `idle` holds through that edge.
- Non-idle input at any edge in IDLE_WAIT: `ACK`=1 after that edge, and `CLK_EN` stays high throughout.
- Minimum `CLK_EN` high time is `WAKE_CYCLES`+1+`IDLE_TIMEOUT` cycles.
- Consumer rule: the consumer must not use the gated clock until `ACK`=1. The consumer keeps `REQ` or `BUSY` high for as long as it needs the clock.

## Structure

- Shared package `clk_gate_pkg` holds:
  - the state localparams (OFF, WAKE, ON, IDLE_WAIT) and the state width of 2;
  - the default values of `WAKE_CYCLES` and `IDLE_TIMEOUT`.
- No sub-module. The block is one FSM plus one down-counter.
- Top level connects `CLK_EN` to the gate cell's enable input.

## Test plan

All scenarios use `WAKE_CYCLES`=2 and `IDLE_TIMEOUT`=4.
1. Release reset with all inputs 0 for 10 cycles -> `CLK_EN`=0, `ACK`=0 and `STATE`=00 throughout.
2. `REQ`=1 sampled at edge 0 -> `CLK_EN`=1 after edge 0, `STATE`=01; `ACK`=1 and `STATE`=10 after edge 2.
3. From ON, drop `REQ` and `BUSY` at edge 10 -> `ACK`=0 after edge 10; `CLK_EN`=0 and `STATE`=00 after edge 14.
4. From IDLE_WAIT, reassert `REQ` at edge 12 -> `ACK`=1 after edge 12; `CLK_EN` never drops.
5. Pulse `REQ` for 1 cycle at edge 0 with `BUSY`=1 until edge 20 -> clock stays on; `CLK_EN` falls after edge 24. Repeat with `FORCE_ON` in place of `REQ`/`BUSY` and the same result.
6. Pull `RST` low mid-WAKE at edge 1 and again mid-IDLE_WAIT -> `CLK_EN`, `ACK` and `STATE` go to 0 immediately (asynchronously). After release, a new `REQ` restarts the full 2-cycle wake window.

Source files
------------

// File: rtl/clk_gate_pkg.sv
// Shared definitions for the clock-gating controller: state encoding and defaults.
package clk_gate_pkg;

    localparam int unsigned STATE_W          = 2;
    localparam int unsigned WAKE_CYCLES_DEF  = 2;
    localparam int unsigned IDLE_TIMEOUT_DEF = 4;
    localparam int unsigned CNT_W_DEF        = 4;

    typedef enum logic [STATE_W-1:0] {
        OFF       = 2'b00,
        WAKE      = 2'b01,
        ON        = 2'b10,
        IDLE_WAIT = 2'b11
    } state_t;

    // Gate enable is high in every state except OFF.
    function automatic logic clk_en_of(input state_t s);
        return (s != OFF);
    endfunction

    // Acknowledge is high only while the clock is running and not winding down.
    function automatic logic ack_of(input state_t s);
        return (s == ON);
    endfunction

endpackage

// File: rtl/clk_gate_ctrl.sv
// Clock-gating controller: wakes the gated clock on request, holds ACK low
// through a settling window, and shuts the clock off after a run of idle cycles.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int unsigned WAKE_CYCLES  = WAKE_CYCLES_DEF,
    parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               REQ,
    input  logic               BUSY,
    input  logic               FORCE_ON,
    output logic               CLK_EN,
    output logic               ACK,
    output logic [STATE_W-1:0] STATE
);

    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             wake;
    logic             idle;

    assign wake = REQ | FORCE_ON;
    assign idle = ~REQ & ~BUSY & ~FORCE_ON;

    // Next-state and shared down-counter update.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            OFF: begin
                if (wake) begin
                    state_nxt = WAKE;
                    cnt_nxt   = WAKE_LOAD;
                end
            end
            WAKE: begin
                // Wake always runs to completion so the enable never toggles mid-window.
                if (cnt == '0) begin
                    state_nxt = ON;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ON: begin
                if (idle) begin
                    state_nxt = IDLE_WAIT;
                    cnt_nxt   = IDLE_LOAD;
                end
            end
            IDLE_WAIT: begin
                // Activity wins over timeout; clock never stopped so no wake window.
                if (!idle) begin
                    state_nxt = ON;
                end else if (cnt == '0) begin
                    state_nxt = OFF;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = OFF;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and outputs registered from the next state so CLK_EN is glitch-free.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= OFF;
            cnt    <= '0;
            CLK_EN <= 1'b0;
            ACK    <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            CLK_EN <= clk_en_of(state_nxt);
            ACK    <= ack_of(state_nxt);
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl with WAKE_CYCLES=2, IDLE_TIMEOUT=4.
module tb_clk_gate_ctrl;

    localparam logic [1:0] S_OFF  = 2'b00;
    localparam logic [1:0] S_WAKE = 2'b01;
    localparam logic [1:0] S_ON   = 2'b10;
    localparam logic [1:0] S_IW   = 2'b11;

    typedef struct packed {
        logic       en;
        logic       ack;
        logic [1:0] st;
    } exp_t;

    logic       CLK;
    logic       RST;
    logic       REQ;
    logic       BUSY;
    logic       FORCE_ON;
    logic       CLK_EN;
    logic       ACK;
    logic [1:0] STATE;

    exp_t sb[$];
    exp_t e;
    int   check_cnt;
    int   pass_cnt;

    clk_gate_ctrl #(
        .WAKE_CYCLES (2),
        .IDLE_TIMEOUT(4),
        .CNT_W       (4)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .BUSY    (BUSY),
        .FORCE_ON(FORCE_ON),
        .CLK_EN  (CLK_EN),
        .ACK     (ACK),
        .STATE   (STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive inputs for one edge, record the expected post-edge outputs, then step past the edge.
    task automatic drive(input logic r, input logic b, input logic f,
                         input logic en, input logic ack, input logic [1:0] st);
        REQ      = r;
        BUSY     = b;
        FORCE_ON = f;
        sb.push_back('{en: en, ack: ack, st: st});
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        sb.push_back('{en: 1'b0, ack: 1'b0, st: S_OFF});
        #3;
        e = sb.pop_front();
        check_cnt++;
        if ({CLK_EN, ACK, STATE} !== {e.en, e.ack, e.st})
            $display("FAIL reset_held: got en=%b ack=%b st=%b want en=%b ack=%b st=%b",
                     CLK_EN, ACK, STATE, e.en, e.ack, e.st);
        else pass_cnt++;
        @(posedge CLK); #1;
        RST = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_OFF);
            e = sb.pop_front();
            check_cnt++;
            if ({CLK_EN, ACK, STATE} !== {e.en, e.ack, e.st})
                $display("FAIL reset_idle edge %0d: got en=%b ack=%b st=%b want en=%b ack=%b st=%b",
                         i, CLK_EN, ACK, STATE, e.en, e.ack, e.st);
            else pass_cnt++;
        end
    endtask

    task automatic test_wake();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, (i >= 2), (i >= 2) ? S_ON : S_WAKE);
            e = sb.pop_front();
            check_cnt++;
            if ({CLK_EN, ACK, STATE} !== {e.en, e.ack, e.st})
                $display("FAIL wake edge %0d: got en=%b ack=%b st=%b want en=%b ack=%b st=%b",
                         i, CLK_EN, ACK, STATE, e.en, e.ack, e.st);
            else pass_cnt++;
        end
    endtask

    task automatic test_idle_off();
        for (int i = 10; i < 17; i++) begin
            drive(1'b0, 1'b0, 1'b0, (i < 14), 1'b0, (i < 14) ? S_IW : S_OFF);
            e = sb.pop_front();
            check_cnt++;
            if ({CLK_EN, ACK, STATE} !== {e.en, e.ack, e.st})
                $display("FAIL idle_off edge %0d: got en=%b ack=%b st=%b want en=%b ack=%b st=%b",
                         i, CLK_EN, ACK, STATE, e.en, e.ack, e.st);
            else pass_cnt++;
        end
    endtask

    task automatic test_rewake();
        logic [1:0] st;
        for (int i = 0; i < 16; i++) begin
            if (i < 2)                 st = S_WAKE;
            else if (i == 10 || i == 11) st = S_IW;
            else                       st = S_ON;
            drive(!(i == 10 || i == 11), 1'b0, 1'b0, 1'b1, (st == S_ON), st);
            e = sb.pop_front();
            check_cnt++;
            if ({CLK_EN, ACK, STATE} !== {e.en, e.ack, e.st})
                $display("FAIL rewake edge %0d: got en=%b ack=%b st=%b want en=%b ack=%b st=%b",
                         i, CLK_EN, ACK, STATE, e.en, e.ack, e.st);
            else pass_cnt++;
        end
    endtask

    // BUSY returns on the very edge the idle counter hits zero; activity must win.
    task automatic test_back_to_back();
        logic [1:0] st;
        logic       b;
        for (int i = 0; i < 13; i++) begin
            b = (i == 4 || i == 5);
            if (i < 4)       st = S_IW;
            else if (i < 6)  st = S_ON;
            else if (i < 10) st = S_IW;
            else             st = S_OFF;
            drive(1'b0, b, 1'b0, (st != S_OFF), (st == S_ON), st);
            e = sb.pop_front();
            check_cnt++;
            if ({CLK_EN, ACK, STATE} !== {e.en, e.ack, e.st})
                $display("FAIL back_to_back edge %0d: got en=%b ack=%b st=%b want en=%b ack=%b st=%b",
                         i, CLK_EN, ACK, STATE, e.en, e.ack, e.st);
            else pass_cnt++;
        end
    endtask

    task automatic test_busy_hold();
        logic [1:0] st;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_OFF);
            e = sb.pop_front();
            check_cnt++;
            if ({CLK_EN, ACK, STATE} !== {e.en, e.ack, e.st})
                $display("FAIL busy_no_wake edge %0d: got en=%b ack=%b st=%b want en=%b ack=%b st=%b",
                         i, CLK_EN, ACK, STATE, e.en, e.ack, e.st);
            else pass_cnt++;
        end
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 27; i++) begin
                if (i < 2)       st = S_WAKE;
                else if (i < 20) st = S_ON;
                else if (i < 24) st = S_IW;
                else             st = S_OFF;
                if (pass == 0) drive((i == 0), (i < 20), 1'b0, (i < 24), (st == S_ON), st);
                else           drive(1'b0, 1'b0, (i < 20), (i < 24), (st == S_ON), st);
                e = sb.pop_front();
                check_cnt++;
                if ({CLK_EN, ACK, STATE} !== {e.en, e.ack, e.st})
                    $display("FAIL hold_%s edge %0d: got en=%b ack=%b st=%b want en=%b ack=%b st=%b",
                             (pass == 0) ? "busy" : "force", i, CLK_EN, ACK, STATE, e.en, e.ack, e.st);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] st;
        for (int phase = 0; phase < 2; phase++) begin
            // Phase 0 asserts reset mid-WAKE (after edge 1); phase 1 mid-IDLE_WAIT.
            for (int i = 0; i < ((phase == 0) ? 2 : 6); i++) begin
                if (i < 2)      st = S_WAKE;
                else if (i < 4) st = S_ON;
                else            st = S_IW;
                drive((i < 4), 1'b0, 1'b0, 1'b1, (st == S_ON), st);
                e = sb.pop_front();
                check_cnt++;
                if ({CLK_EN, ACK, STATE} !== {e.en, e.ack, e.st})
                    $display("FAIL rst_mid_pre%0d edge %0d: got en=%b ack=%b st=%b want en=%b ack=%b st=%b",
                             phase, i, CLK_EN, ACK, STATE, e.en, e.ack, e.st);
                else pass_cnt++;
            end
            RST = 1'b0;
            sb.push_back('{en: 1'b0, ack: 1'b0, st: S_OFF});
            #1;
            e = sb.pop_front();
            check_cnt++;
            if ({CLK_EN, ACK, STATE} !== {e.en, e.ack, e.st})
                $display("FAIL rst_mid_async%0d: got en=%b ack=%b st=%b want en=%b ack=%b st=%b",
                         phase, CLK_EN, ACK, STATE, e.en, e.ack, e.st);
            else pass_cnt++;
            REQ = 1'b0;
            @(posedge CLK); #1;
            RST = 1'b1;
            for (int i = 0; i < 9; i++) begin
                if (i < 2)      st = S_WAKE;
                else if (i < 4) st = S_ON;
                else if (i < 8) st = S_IW;
                else            st = S_OFF;
                drive((i < 4), 1'b0, 1'b0, (st != S_OFF), (st == S_ON), st);
                e = sb.pop_front();
                check_cnt++;
                if ({CLK_EN, ACK, STATE} !== {e.en, e.ack, e.st})
                    $display("FAIL rst_mid_post%0d edge %0d: got en=%b ack=%b st=%b want en=%b ack=%b st=%b",
                             phase, i, CLK_EN, ACK, STATE, e.en, e.ack, e.st);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        check_cnt = 0;
        pass_cnt  = 0;
        RST       = 1'b0;
        REQ       = 1'b0;
        BUSY      = 1'b0;
        FORCE_ON  = 1'b0;
        test_reset();
        test_wake();
        test_idle_off();
        test_rewake();
        test_back_to_back();
        test_busy_hold();
        test_reset_mid();
        if (sb.size() != 0) begin
            check_cnt++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
